// File: rtl/mmio_defs.sv
// Shared MMIO definitions for the button/LED controller: default register
// addresses, status-word bit positions and debounce state encodings.
package mmio_defs;

    localparam logic [31:0] BTN_ADDR_DEF = 32'd1000;
    localparam logic [31:0] OUT_ADDR_DEF = 32'd2000;
    localparam logic [31:0] CNT_ADDR_DEF = 32'd1001;

    localparam int BTN_LEVEL_BIT = 0;
    localparam int BTN_PEND_BIT  = 1;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_CHANGING = 1'b1
    } db_state_e;

endpackage

// File: rtl/mmio_button_io_if.sv
// Processor data-memory port as seen by the MMIO controller. The master side
// is the processor plus RAM (it also supplies q_ram); the slave is the controller.
interface mmio_button_io_if;

    logic [31:0] address_dmem;
    logic        wren;
    logic        rden;
    logic [31:0] data;
    logic [31:0] q_ram;
    logic [31:0] q_dmem;
    logic        ram_wren;

    modport master (
        output address_dmem, wren, rden, data, q_ram,
        input  q_dmem, ram_wren
    );

    modport slave (
        input  address_dmem, wren, rden, data, q_ram,
        output q_dmem, ram_wren
    );

endinterface

// File: rtl/mmio_button_io_debounce.sv
// Button synchroniser and debouncer: a new level is accepted only after
// DEBOUNCE_CYCLES consecutive synchronised samples disagree with the current one.
module button_debounce
    import mmio_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic btn_level,
    output logic rise_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             btn_s;

    assign btn_s     = sync_q[1];
    assign btn_level = level_q;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        sync_d     = {sync_q[0], button_raw};
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        rise_pulse = 1'b0;
        unique case (state_q)
            DB_STABLE: begin
                if (btn_s != level_q) begin
                    state_d = DB_CHANGING;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            DB_CHANGING: begin
                if (btn_s == level_q) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    // '>=' also covers DEBOUNCE_CYCLES==1, where the entry count already exceeds the limit.
                    level_d    = btn_s;
                    rise_pulse = btn_s;
                    state_d    = DB_STABLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/mmio_button_io.sv
// MMIO controller: button status, LED output register, RAM pass-through.
// Optional press counter at CNT_ADDR is enabled by defining MMIO_PRESS_COUNT_EN.
module mmio_button_io
    import mmio_defs::*;
#(
    parameter logic [31:0] BTN_ADDR = BTN_ADDR_DEF,
    parameter logic [31:0] OUT_ADDR = OUT_ADDR_DEF,
`ifdef MMIO_PRESS_COUNT_EN
    parameter logic [31:0] CNT_ADDR = CNT_ADDR_DEF,
`endif
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    mmio_button_io_if.slave         bus,
    input  logic                    button_raw,
    output logic [31:0]             out_reg
);

    logic        btn_level;
    logic        rise_pulse;
    logic        btn_hit, out_hit, mmio_hit;
    logic        pend_q, pend_d;
    logic [31:0] out_q, out_d;
    logic [31:0] status;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock      (clock),
        .reset      (reset),
        .button_raw (button_raw),
        .btn_level  (btn_level),
        .rise_pulse (rise_pulse)
    );

    // Full 32-bit compares: no partial decode, so no aliasing of the registers.
    assign btn_hit = (bus.address_dmem == BTN_ADDR);
    assign out_hit = (bus.address_dmem == OUT_ADDR);

`ifdef MMIO_PRESS_COUNT_EN
    logic        cnt_hit;
    logic [15:0] press_cnt_q, press_cnt_d;

    assign cnt_hit  = (bus.address_dmem == CNT_ADDR);
    assign mmio_hit = btn_hit | out_hit | cnt_hit;

    always_comb begin
        press_cnt_d = press_cnt_q;
        if (bus.wren && cnt_hit) begin
            press_cnt_d = '0;
        end else if (rise_pulse && press_cnt_q != 16'hFFFF) begin
            press_cnt_d = press_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) press_cnt_q <= '0;
        else        press_cnt_q <= press_cnt_d;
    end
`else
    assign mmio_hit = btn_hit | out_hit;
`endif

    assign bus.ram_wren = bus.wren & ~mmio_hit;
    assign out_reg      = out_q;

    always_comb begin
        status                = '0;
        status[BTN_LEVEL_BIT] = btn_level;
        status[BTN_PEND_BIT]  = pend_q;

        // A press committing on the same edge as the clearing load must not be lost.
        pend_d = pend_q;
        if (rise_pulse) begin
            pend_d = 1'b1;
        end else if (bus.rden && btn_hit) begin
            pend_d = 1'b0;
        end

        out_d = out_q;
        if (bus.wren && out_hit) begin
            out_d = bus.data;
        end

        bus.q_dmem = bus.q_ram;
        if (btn_hit) begin
            bus.q_dmem = status;
        end else if (out_hit) begin
            bus.q_dmem = out_q;
        end
`ifdef MMIO_PRESS_COUNT_EN
        else if (cnt_hit) begin
            bus.q_dmem = {16'b0, press_cnt_q};
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q <= 1'b0;
            out_q  <= '0;
        end else begin
            pend_q <= pend_d;
            out_q  <= out_d;
        end
    end

endmodule
